// File: rtl/zeroriscy_mp_sram.sv
// Multi-port behavioural SRAM for the zero-riscy bench: NPORTS request/grant/rvalid ports on one word array.
// Optional randomised grant stalls are built in when ZERORISCY_SRAM_STALL_EN is defined.
module zeroriscy_mp_sram #(
  parameter int          NPORTS     = 2,
  parameter int          NWORDS     = 65536,
  parameter int          LATENCY    = 1,
  parameter logic [31:0] BASE_ADDR  = 32'h0,
  parameter logic [15:0] STALL_SEED = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NPORTS-1:0]    req,
  input  logic [NPORTS-1:0]    we,
  input  logic [4*NPORTS-1:0]  be,
  input  logic [32*NPORTS-1:0] addr,
  input  logic [32*NPORTS-1:0] wdata,
  output logic [32*NPORTS-1:0] rdata,
  output logic [NPORTS-1:0]    gnt,
  output logic [NPORTS-1:0]    rvalid,
  output logic [NPORTS-1:0]    err
);

  localparam int AW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  logic [31:0]       mem_q [NWORDS];
  logic [NPORTS-1:0] stall;
  logic [NPORTS-1:0] in_rng;
  logic [NPORTS-1:0] wr_en;
  logic [31:0]       offs    [NPORTS];
  logic [AW-1:0]     widx    [NPORTS];
  logic [31:0]       rd_word [NPORTS];

  // Response shift registers, one per port; index LATENCY-1 drives the outputs.
  logic              rsp_vld_q [NPORTS][LATENCY];
  logic              rsp_vld_d [NPORTS][LATENCY];
  logic              rsp_err_q [NPORTS][LATENCY];
  logic              rsp_err_d [NPORTS][LATENCY];
  logic [31:0]       rsp_dat_q [NPORTS][LATENCY];
  logic [31:0]       rsp_dat_d [NPORTS][LATENCY];

  assign gnt = req & ~stall & {NPORTS{rst_n}};

  // Address decode and read of the pre-edge array contents (read-before-write).
  always_comb begin
    for (int i = 0; i < NPORTS; i++) begin
      offs[i]    = addr[32*i +: 32] - BASE_ADDR;
      in_rng[i]  = (addr[32*i +: 32] >= BASE_ADDR) && ((offs[i] >> 2) < 32'(NWORDS));
      widx[i]    = offs[i][AW+1:2];
      rd_word[i] = in_rng[i] ? mem_q[widx[i]] : 32'h0;
      wr_en[i]   = gnt[i] & we[i] & in_rng[i];
    end
  end

  // Highest port index is applied first so lower indices overwrite it on shared lanes.
  always_ff @(posedge clk) begin
    for (int i = NPORTS - 1; i >= 0; i--) begin
      if (wr_en[i]) begin
        for (int b = 0; b < 4; b++) begin
          if (be[4*i+b]) begin
            mem_q[widx[i]][8*b +: 8] <= wdata[32*i + 8*b +: 8];
          end
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NPORTS; i++) begin
      rsp_vld_d[i][0] = gnt[i];
      rsp_err_d[i][0] = gnt[i] & ~in_rng[i];
      rsp_dat_d[i][0] = (gnt[i] & ~we[i]) ? rd_word[i] : 32'h0;
      for (int s = 1; s < LATENCY; s++) begin
        rsp_vld_d[i][s] = rsp_vld_q[i][s-1];
        rsp_err_d[i][s] = rsp_err_q[i][s-1];
        rsp_dat_d[i][s] = rsp_dat_q[i][s-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NPORTS; i++) begin
        for (int s = 0; s < LATENCY; s++) begin
          rsp_vld_q[i][s] <= 1'b0;
          rsp_err_q[i][s] <= 1'b0;
          rsp_dat_q[i][s] <= 32'h0;
        end
      end
    end else begin
      for (int i = 0; i < NPORTS; i++) begin
        for (int s = 0; s < LATENCY; s++) begin
          rsp_vld_q[i][s] <= rsp_vld_d[i][s];
          rsp_err_q[i][s] <= rsp_err_d[i][s];
          rsp_dat_q[i][s] <= rsp_dat_d[i][s];
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NPORTS; i++) begin
      rvalid[i]          = rsp_vld_q[i][LATENCY-1];
      err[i]             = rsp_err_q[i][LATENCY-1];
      rdata[32*i +: 32]  = rsp_dat_q[i][LATENCY-1];
    end
  end

`ifdef ZERORISCY_SRAM_STALL_EN
  logic [15:0] lfsr_q [NPORTS];
  logic [15:0] lfsr_d [NPORTS];
  logic [1:0]  wait_q [NPORTS];
  logic [1:0]  wait_d [NPORTS];

  // Fibonacci LFSR, taps 16,14,13,11; a third consecutive stall forces the grant.
  always_comb begin
    for (int i = 0; i < NPORTS; i++) begin
      lfsr_d[i] = {lfsr_q[i][14:0],
                   lfsr_q[i][15] ^ lfsr_q[i][13] ^ lfsr_q[i][12] ^ lfsr_q[i][10]};
      stall[i]  = req[i] & (lfsr_q[i][1:0] == 2'b00) & (wait_q[i] != 2'd3);
    end
  end

  always_comb begin
    for (int i = 0; i < NPORTS; i++) begin
      wait_d[i] = (!req[i] || gnt[i]) ? 2'd0 : wait_q[i] + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NPORTS; i++) begin
        lfsr_q[i] <= STALL_SEED ^ 16'(i);
        wait_q[i] <= 2'd0;
      end
    end else begin
      for (int i = 0; i < NPORTS; i++) begin
        lfsr_q[i] <= lfsr_d[i];
        wait_q[i] <= wait_d[i];
      end
    end
  end
`else
  always_comb begin
    stall = '0;
  end
`endif

endmodule

// File: tb/tb_zeroriscy_mp_sram.sv
// Scoreboard bench for zeroriscy_mp_sram: a reference memory predicts each response when it is
// granted, and the prediction is compared when rvalid is due LATENCY cycles later.
module tb_zeroriscy_mp_sram;

  localparam int          NP   = 3;
  localparam int          NW   = 256;
  localparam int          LAT  = 2;
  localparam logic [31:0] BASE = 32'h0000_1000;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NP-1:0]   req, we, gnt, rvalid, err;
  logic [4*NP-1:0] be;
  logic [32*NP-1:0] addr, wdata, rdata;

  always #5 clk = ~clk;

  zeroriscy_mp_sram #(
    .NPORTS    (NP),
    .NWORDS    (NW),
    .LATENCY   (LAT),
    .BASE_ADDR (BASE),
    .STALL_SEED(16'hACE1)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .we    (we),
    .be    (be),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .gnt   (gnt),
    .rvalid(rvalid),
    .err   (err)
  );

  typedef struct {
    int          due;
    logic        e;
    logic [31:0] d;
  } rsp_t;

  rsp_t        sbq [NP][$];
  logic [31:0] model [NW];
  logic [NP-1:0] ovr_en;
  logic [31:0] ovr_val [NP];
  logic [NP-1:0] g_last;
  int          cyc, n_chk, n_fail;
  int          k, guard;
  bit          seq [2][1000];
  int          run, maxrun, ngnt, diff;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic oob(input logic [31:0] a);
    return (a < BASE) || (((a - BASE) >> 2) >= 32'(NW));
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  task automatic idle();
    req = '0;
    we  = '0;
    be  = '0;
  endtask

  task automatic drive(input int p, input logic w, input logic [3:0] b,
                       input logic [31:0] a, input logic [31:0] d);
    req[p]          = 1'b1;
    we[p]           = w;
    be[4*p +: 4]    = b;
    addr[32*p +: 32]  = a;
    wdata[32*p +: 32] = d;
  endtask

  task automatic expect_rd(input int p, input logic [31:0] v);
    ovr_en[p]  = 1'b1;
    ovr_val[p] = v;
  endtask

  task automatic check_rsp();
    rsp_t r;
    for (int p = 0; p < NP; p++) begin
      if (sbq[p].size() > 0 && sbq[p][0].due == cyc) begin
        r = sbq[p].pop_front();
        check_eq($sformatf("rvalid[%0d]", p), 32'(rvalid[p]), 32'd1);
        check_eq($sformatf("rdata[%0d]", p), rdata[32*p +: 32], r.d);
        check_eq($sformatf("err[%0d]", p), 32'(err[p]), 32'(r.e));
      end else begin
        check_eq($sformatf("rvalid_idle[%0d]", p), 32'(rvalid[p]), 32'd0);
      end
    end
    if (!rst_n) begin
      check_eq("rst_rdata", 32'(|rdata), 32'd0);
      check_eq("rst_err", 32'(err), 32'd0);
    end
  endtask

  // One clock cycle: predict from the current inputs, clock, then check responses due now.
  task automatic step();
    rsp_t r;
    logic [31:0] a;
    #1;
    g_last = gnt;
`ifdef ZERORISCY_SRAM_STALL_EN
    check_eq("gnt_without_req", 32'(gnt & ~(req & {NP{rst_n}})), 32'd0);
`else
    check_eq("gnt", 32'(gnt), 32'(req & {NP{rst_n}}));
`endif
    for (int p = 0; p < NP; p++) begin
      if (gnt[p]) begin
        a     = addr[32*p +: 32];
        r.due = cyc + LAT;
        r.e   = oob(a);
        r.d   = 32'h0;
        if (!r.e && !we[p]) r.d = model[widx(a)];
        if (ovr_en[p]) r.d = ovr_val[p];
        sbq[p].push_back(r);
      end
    end
    ovr_en = '0;
    for (int p = NP - 1; p >= 0; p--) begin
      a = addr[32*p +: 32];
      if (gnt[p] && we[p] && !oob(a)) begin
        for (int b = 0; b < 4; b++) begin
          if (be[4*p+b]) model[widx(a)][8*b +: 8] = wdata[32*p + 8*b +: 8];
        end
      end
    end
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      for (int p = 0; p < NP; p++) sbq[p].delete();
    end
    @(negedge clk);
    check_rsp();
  endtask

  task automatic drain(input int n);
    idle();
    repeat (n) step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_fail = 0; cyc = 0;
    ovr_en = '0;
    idle();
    addr = '0; wdata = '0;
    rst_n = 1'b0;
    @(negedge clk);

    // Requests during reset must not be granted; outputs stay zero.
    for (int p = 0; p < NP; p++) drive(p, 1'b0, 4'h0, BASE, 32'h0);
    repeat (3) step();
    idle();
    rst_n = 1'b1;

    // Clear the words the bench uses so the reference memory is fully known.
    k = 0; guard = 0;
    while (k < NW && guard < 4000) begin
      idle();
      drive(0, 1'b1, 4'hF, BASE + 32'(4*k), 32'h0);
      step();
      if (g_last[0]) k++;
      guard++;
    end
    check_eq("init_done", 32'(k), 32'(NW));
    drain(LAT + 1);

    // Write then read from another port.
    drive(0, 1'b1, 4'hF, BASE + 32'h100, 32'hDEADBEEF);
    step(); idle();
    drive(1, 1'b0, 4'h0, BASE + 32'h100, 32'h0);
    expect_rd(1, 32'hDEADBEEF);
    step();
    drain(LAT + 1);

    // Two-port lane merge, then three-port merge with lowest index winning.
    drive(0, 1'b1, 4'b0011, BASE + 32'h40, 32'h11112222);
    drive(1, 1'b1, 4'b0110, BASE + 32'h40, 32'h33334444);
    step(); idle();
    drive(0, 1'b1, 4'b0011, BASE + 32'h48, 32'h11112222);
    drive(1, 1'b1, 4'b0110, BASE + 32'h48, 32'h33334444);
    drive(2, 1'b1, 4'b1100, BASE + 32'h48, 32'h55556666);
    step(); idle();
    drive(2, 1'b0, 4'h0, BASE + 32'h40, 32'h0);
    expect_rd(2, 32'h00332222);
    step(); idle();
    drive(2, 1'b0, 4'h0, BASE + 32'h48, 32'h0);
    expect_rd(2, 32'h55332222);
    step();
    drain(LAT + 1);

    // Back-to-back reads on one port return in order on consecutive cycles.
    drive(0, 1'b0, 4'h0, BASE + 32'h100, 32'h0); expect_rd(0, 32'hDEADBEEF); step();
    drive(0, 1'b0, 4'h0, BASE + 32'h40,  32'h0); expect_rd(0, 32'h00332222); step();
    drive(0, 1'b0, 4'h0, BASE + 32'h48,  32'h0); expect_rd(0, 32'h55332222); step();
    drain(LAT + 1);

    // Same-cycle write is invisible to a read of that word; visible one cycle later.
    drive(0, 1'b1, 4'hF, BASE + 32'h100, 32'hCAFEF00D);
    drive(2, 1'b0, 4'h0, BASE + 32'h100, 32'h0);
    expect_rd(2, 32'hDEADBEEF);
    step(); idle();
    drive(1, 1'b0, 4'h0, BASE + 32'h103, 32'h0);
    expect_rd(1, 32'hCAFEF00D);
    step();
    drain(LAT + 1);

    // Out-of-range accesses error out and must not alias onto real words.
    drive(0, 1'b1, 4'hF, BASE + 32'(4*NW), 32'hAAAA5555);
    drive(1, 1'b0, 4'h0, BASE + 32'(4*NW), 32'h0);
    drive(2, 1'b1, 4'hF, BASE - 32'h4, 32'h5555AAAA);
    step(); idle();
    drive(0, 1'b0, 4'h0, BASE, 32'h0);                  expect_rd(0, 32'h0);
    drive(1, 1'b0, 4'h0, BASE + 32'(4*(NW-1)), 32'h0);  expect_rd(1, 32'h0);
    step();
    drain(LAT + 1);

    // Reset one cycle after a read grant drops the response; memory survives.
    drive(0, 1'b0, 4'h0, BASE + 32'h100, 32'h0);
    step(); idle();
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    drain(LAT + 2);
    drive(1, 1'b0, 4'h0, BASE + 32'h100, 32'h0);
    expect_rd(1, 32'hCAFEF00D);
    step();
    drain(LAT + 1);

    // Random mixed traffic on all ports, including out-of-range addresses.
    repeat (400) begin
      idle();
      for (int p = 0; p < NP; p++) begin
        if ($urandom_range(0, 3) != 0) begin
          int sel;
          logic [31:0] a;
          sel = $urandom_range(0, 15);
          if (sel == 0)      a = BASE + 32'(4*NW) + 32'(4*$urandom_range(0, 7));
          else if (sel == 1) a = BASE - 32'(4*$urandom_range(1, 4));
          else               a = BASE + 32'(4*$urandom_range(0, 15)) + 32'($urandom_range(0, 3));
          drive(p, 1'($urandom_range(0, 1)), 4'($urandom), a, $urandom);
        end
      end
      step();
    end
    drain(LAT + 1);

`ifdef ZERORISCY_SRAM_STALL_EN
    // Stall injection: bounded wait, expected grant rate, and reproducible sequence.
    for (int t = 0; t < 2; t++) begin
      idle();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      drive(0, 1'b0, 4'h0, BASE, 32'h0);
      run = 0; maxrun = 0; ngnt = 0;
      for (int c = 0; c < 1000; c++) begin
        step();
        seq[t][c] = g_last[0];
        if (g_last[0]) begin
          ngnt++;
          run = 0;
        end else begin
          run++;
          if (run > maxrun) maxrun = run;
        end
      end
      drain(LAT + 1);
      check_eq("stall_max_wait_le3", 32'(maxrun <= 3), 32'd1);
      check_eq("stall_grant_rate", 32'(ngnt >= 700 && ngnt <= 850), 32'd1);
    end
    diff = 0;
    for (int c = 0; c < 1000; c++) if (seq[0][c] != seq[1][c]) diff++;
    check_eq("stall_seq_repeat", 32'(diff), 32'd0);
`endif

    for (int p = 0; p < NP; p++) begin
      check_eq($sformatf("sb_empty[%0d]", p), 32'(sbq[p].size()), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
